// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one async-FIFO write port
//
// Ports:
//   wclk, wrst_n   write clock; asynchronous active-low reset (already synchronised)
//   req            per-requester beat valid, held until acked
//   req_data       requester i data on [i*DSIZE +: DSIZE]
//   ack            one-hot, beat of the owner consumed this cycle
//   gnt            registered one-hot owner, zero when idle
//   wdata, winc    to the FIFO write side
//   wfull          FIFO full, synchronous to wclk
//   beats_total    saturating count of beats written
module fifo_write_arbiter #(
    parameter int N         = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic [N-1:0]       req,
    input  logic [N*DSIZE-1:0] req_data,
    output logic [N-1:0]       ack,
    output logic [N-1:0]       gnt,
    output logic [DSIZE-1:0]   wdata,
    output logic               winc,
    input  logic               wfull,
    output logic [15:0]        beats_total
);

    localparam int OW = $clog2(N);
    // A one-beat burst still needs a one-bit counter to keep the compare legal.
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [15:0]     beats_total_q, beats_total_d;

    logic [OW-1:0]   pick;
    logic            pick_valid;
    logic [OW:0]     cand;

    // Search from last_owner+1 upward (mod N). The loop runs from the farthest
    // offset down to the nearest so the nearest requester is written last and wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = {1'b0, last_owner_q} + (OW+1)'(j + 1);
            if (cand >= (OW+1)'(N)) begin
                cand = cand - (OW+1)'(N);
            end
            if (req[cand[OW-1:0]]) begin
                pick       = cand[OW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        beat_cnt_d    = beat_cnt_q;
        gnt_d         = gnt_q;
        beats_total_d = beats_total_q;
        winc          = 1'b0;
        ack           = '0;
        wdata         = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick;
                    gnt_d      = N'(1) << pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                for (int i = 0; i < N; i++) begin
                    if (owner_q == OW'(i)) begin
                        wdata = req_data[i*DSIZE +: DSIZE];
                    end
                end
                winc         = req[owner_q] & ~wfull;
                ack[owner_q] = winc;
                if (winc) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beats_total_q != 16'hFFFF) begin
                        beats_total_d = beats_total_q + 16'd1;
                    end
                end
                // A stalled final beat (wfull) keeps the burst open; a released
                // request closes it even while full.
                if ((winc && (beat_cnt_q == LAST_BEAT)) || !req[owner_q]) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_owner_q  <= OW'(N - 1);
            beat_cnt_q    <= '0;
            gnt_q         <= '0;
            beats_total_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            beat_cnt_q    <= beat_cnt_d;
            gnt_q         <= gnt_d;
            beats_total_q <= beats_total_d;
        end
    end

    assign gnt         = gnt_q;
    assign beats_total = beats_total_q;

    assert property (@(posedge wclk) disable iff (!wrst_n) !(winc && wfull));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack, gnt;
    logic [DW-1:0]   wdata;
    logic            winc;
    logic            wfull = 1'b0;
    logic [15:0]     beats_total;

    logic            sat_rst_n = 1'b0;
    logic [1:0]      sat_req = 2'b11;
    logic [15:0]     sat_req_data = 16'h5A3C;
    logic [1:0]      sat_ack, sat_gnt;
    logic [7:0]      sat_wdata;
    logic            sat_winc;
    logic            sat_wfull = 1'b0;
    logic [15:0]     sat_total;
    bit              sat_done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] src_q [N][$];
    logic [7:0] exp_q [N][$];
    logic [7:0] fifo_q [$];
    logic [N-1:0] en = '1;
    bit           rd_en = 1'b0;
    logic         s_winc;
    logic [7:0]   s_wdata;
    logic [N-1:0] s_ack, s_gnt;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(.N(N), .DSIZE(DW), .MAX_BURST(MB)) u_dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .ack(ack), .gnt(gnt), .wdata(wdata), .winc(winc), .wfull(wfull),
        .beats_total(beats_total)
    );

    fifo_write_arbiter #(.N(2), .DSIZE(8), .MAX_BURST(16)) u_sat (
        .wclk(wclk), .wrst_n(sat_rst_n), .req(sat_req), .req_data(sat_req_data),
        .ack(sat_ack), .gnt(sat_gnt), .wdata(sat_wdata), .winc(sat_winc), .wfull(sat_wfull),
        .beats_total(sat_total)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += src_q[k].size();
        return s;
    endfunction

    task automatic push_beat(input int i, input logic [7:0] d);
        src_q[i].push_back(d);
        exp_q[i].push_back(d);
    endtask

    // Posedge: FIFO model and requester queues consume what was sampled at the
    // previous negedge; inputs then change 1 time unit after the edge.
    task automatic edge_half();
        logic [7:0] tmp;
        @(posedge wclk);
        if (wrst_n) begin
            if (s_winc) fifo_q.push_back(s_wdata);
            for (int i = 0; i < N; i++) begin
                if (s_ack[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
            end
        end
        if (rd_en && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        #1;
        wfull = (fifo_q.size() >= 16);
        for (int i = 0; i < N; i++) begin
            req[i] = en[i] && (src_q[i].size() > 0);
            req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    task automatic sample_half();
        @(negedge wclk);
        s_winc  = winc;
        s_wdata = wdata;
        s_ack   = ack;
        s_gnt   = gnt;
    endtask

    task automatic cyc();
        edge_half();
        sample_half();
    endtask

    task automatic drain(input string name);
        int g = 0;
        rd_en = 1'b1;
        while (pending() > 0 && g < 3000) begin
            cyc();
            g++;
        end
        chk(name, pending(), 0);
        repeat (3) cyc();
    endtask

    // Monitor: checks every negedge against the arbitration rules and pops the
    // per-requester scoreboard on each write.
    always @(negedge wclk) begin : monitor
        static int m_last = N - 1;
        static int m_cnt = 0;
        static int m_total = 0;
        static logic [N-1:0] p_gnt = '0;
        static logic [N-1:0] p_req = '0;
        static logic p_winc = 1'b0;
        int own, e;
        logic [7:0] d;
        if (!wrst_n) begin
            chk("rst_gnt_zero", gnt, 0);
            chk("rst_winc_zero", winc, 0);
            chk("rst_ack_zero", ack, 0);
            chk("rst_total_zero", beats_total, 0);
            m_last = N - 1; m_cnt = 0; m_total = 0;
            p_gnt = '0; p_req = '0; p_winc = 1'b0;
        end else begin
            if (p_gnt == '0) begin
                if (gnt != '0 || p_req != '0) begin
                    e = rr_pick(p_req, m_last);
                    chk("rr_grant", gnt, (e < 0) ? 0 : (1 << e));
                end
                m_cnt = 0;
            end else begin
                own = idx_of(p_gnt);
                if ((p_winc && m_cnt == MB) || !p_req[own]) begin
                    chk("burst_exit", gnt, 0);
                    m_last = own;
                end else begin
                    chk("burst_hold", gnt, p_gnt);
                end
            end
            chk("gnt_onehot0", $countones(gnt) <= 1, 1);
            if (gnt != '0) begin
                own = idx_of(gnt);
                chk("winc_rule", winc, req[own] & ~wfull);
                chk("wdata_sel", wdata, req_data[own*DW +: DW]);
            end else begin
                chk("winc_idle", winc, 0);
            end
            chk("ack_rule", ack, winc ? gnt : '0);
            chk("no_write_full", winc & wfull, 0);
            chk("beats_total", beats_total, (m_total > 65535) ? 65535 : m_total);
            if (winc && gnt != '0) begin
                own = idx_of(gnt);
                if (exp_q[own].size() == 0) begin
                    chk("spurious_write", 1, 0);
                end else begin
                    d = exp_q[own].pop_front();
                    chk("scoreboard_data", wdata, d);
                end
                m_total++;
                m_cnt++;
            end
            p_gnt = gnt; p_req = req; p_winc = winc;
        end
    end

    initial begin : sat_proc
        int n, c, wsum;
        n = 0; c = 0; wsum = 0;
        repeat (2) @(posedge wclk);
        #1 sat_rst_n = 1'b1;
        while (n < 65540 && c < 80000) begin
            @(negedge wclk);
            c++;
            if (n == 1000) chk("sat_count_1000", sat_total, 1000);
            if (n == 65534) chk("sat_count_65534", sat_total, 65534);
            if (sat_winc) n++;
        end
        chk("sat_reached", n, 65540);
        repeat (20) begin
            @(negedge wclk);
            chk("sat_hold", sat_total, 16'hFFFF);
            if (sat_winc) wsum++;
        end
        chk("sat_keeps_writing", wsum >= 17, 1);
        sat_done = 1'b1;
    end

    initial begin : main
        int g, a1;
        int order [$];
        logic [N-1:0] pg;
        s_winc = 1'b0; s_wdata = '0; s_ack = '0; s_gnt = '0;

        repeat (2) @(negedge wclk);
        chk("reset_gnt", gnt, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_total", beats_total, 0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        sample_half();
        rd_en = 1'b1;

        // Single requester: 4-beat burst, one IDLE cycle, then the fifth beat.
        for (int k = 0; k < 5; k++) push_beat(0, 8'(8'h10 + k));
        cyc();
        chk("t1_gnt_before", s_gnt, 0);
        cyc();
        chk("t1_gnt", s_gnt, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            chk("t1_winc", s_winc, 1);
            chk("t1_wdata", s_wdata, 8'h10 + k);
            cyc();
        end
        chk("t1_gap_gnt", s_gnt, 0);
        chk("t1_gap_winc", s_winc, 0);
        cyc();
        chk("t1_beat5_gnt", s_gnt, 4'b0001);
        chk("t1_beat5_data", s_wdata, 8'h14);
        chk("t1_beat5_winc", s_winc, 1);
        cyc(); cyc();
        chk("t1_total", beats_total, 5);

        // Reset while the second beat of requester 0 is presented.
        for (int k = 0; k < 4; k++) push_beat(0, 8'(8'h20 + k));
        g = 0;
        while (!s_winc && g < 20) begin cyc(); g++; end
        chk("rst_mid_first_beat", s_winc, 1);
        edge_half();
        #1 wrst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_winc", winc, 0);
        chk("rst_mid_total", beats_total, 0);
        s_winc = 1'b0; s_ack = '0;
        sample_half();
        edge_half();
        wrst_n = 1'b1;
        sample_half();

        // Round-robin fairness with every requester held.
        for (int k = 0; k < 5; k++) push_beat(0, 8'(8'h30 + k));
        for (int i = 1; i < N; i++)
            for (int k = 0; k < 8; k++) push_beat(i, 8'(8'h40 + 16*i + k));
        pg = '0; g = 0;
        while (order.size() < 5 && g < 200) begin
            if (s_gnt != '0 && pg == '0) order.push_back(idx_of(s_gnt));
            pg = s_gnt;
            cyc();
            g++;
        end
        chk("rr_order_len", order.size(), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", (k < order.size()) ? order[k] : -1, k % N);
        drain("rr_drain");

        // Early release: requester 1 drops after two beats; 3 must beat 0.
        for (int k = 0; k < 4; k++) push_beat(1, 8'(8'h60 + k));
        g = 0;
        while (s_gnt != 4'b0010 && g < 20) begin cyc(); g++; end
        chk("er_gnt1", s_gnt, 4'b0010);
        push_beat(0, 8'h70);
        push_beat(3, 8'h73);
        a1 = 0; g = 0;
        while (a1 < 2 && g < 20) begin
            if (s_ack[1]) a1++;
            if (a1 < 2) cyc();
            g++;
        end
        chk("er_two_acks", a1, 2);
        en[1] = 1'b0;
        cyc();
        chk("er_hold_gnt", s_gnt, 4'b0010);
        chk("er_no_winc", s_winc, 0);
        cyc();
        chk("er_idle", s_gnt, 0);
        cyc();
        chk("er_next_owner", s_gnt, 4'b1000);
        en[1] = 1'b1;
        drain("er_drain");

        // Backpressure: fill the 16-deep FIFO, then free one slot for 0xA5.
        g = 0;
        while (fifo_q.size() > 0 && g < 50) begin cyc(); g++; end
        rd_en = 1'b0;
        for (int k = 0; k < 16; k++) push_beat(2, 8'($urandom));
        push_beat(2, 8'hA5);
        g = 0;
        while (fifo_q.size() < 16 && g < 100) begin cyc(); g++; end
        chk("bp_full", wfull, 1);
        cyc(); cyc();
        for (int k = 0; k < 4; k++) begin
            chk("bp_gnt_held", s_gnt, 4'b0100);
            chk("bp_no_winc", s_winc, 0);
            cyc();
        end
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        g = 0;
        while (!s_winc && g < 5) begin cyc(); g++; end
        chk("bp_resume_winc", s_winc, 1);
        chk("bp_resume_data", s_wdata, 8'hA5);
        chk("bp_resume_ack", s_ack, 4'b0100);
        drain("bp_drain");

        // Randomised traffic with random FIFO reads to create backpressure.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && src_q[i].size() < 6) push_beat(i, 8'($urandom));
            rd_en = ($urandom_range(0, 99) < 55);
            cyc();
        end
        drain("rand_drain");
        for (int i = 0; i < N; i++) chk("scoreboard_empty", exp_q[i].size(), 0);

        g = 0;
        while (!sat_done && g < 90000) begin @(negedge wclk); g++; end
        chk("sat_done", sat_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
